pkt_src_arbiter: RTL and testbench

Arbitrates up to NUM_REQ packet sources onto the single serial packet input of the port router (`data_in`/`valid_in`). Each source presents a 64-bit packet with a request. The arbiter grants one source and serialises its packet MSB-first as 64 consecutive valid bits. It then holds a quiet gap so the router can drain before the next packet. An APB register bank configures enable, arbitration mode and source mask, and reports status.

---
 rtl/pkt_src_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 36 +++
 rtl/pkt_src_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_pkt_src_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_src_arb_pkg.sv
// Shared types and constants for the packet source arbiter: FSM states,
// APB register map and CTRL bit positions.
package pkt_src_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    localparam logic [31:0] ADDR_CTRL     = 32'h0000_0000;
    localparam logic [31:0] ADDR_MASK     = 32'h0000_0004;
    localparam logic [31:0] ADDR_STATUS   = 32'h0000_0008;
    localparam logic [31:0] ADDR_CNT_CLR  = 32'h0000_000C;
    localparam logic [31:0] ADDR_CNT_BASE = 32'h0000_0010;

    localparam int PKT_W_DEF = 64;

    localparam int CTRL_ARB_EN = 0;
    localparam int CTRL_MODE   = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: scans from start (round-robin, mode=0) or
// from index 0 (fixed priority, mode=1) and returns the first eligible source.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         elig,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    input  logic                       mode,
    output logic [NUM_REQ-1:0]         win,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       found
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW:0] cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = mode ? (IW+1)'(i) : ({1'b0, start} + (IW+1)'(i));
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!found && elig[cand[IW-1:0]]) begin
                found                = 1'b1;
                win[cand[IW-1:0]]    = 1'b1;
                win_idx              = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/pkt_src_arbiter.sv
// Arbitrates NUM_REQ packet sources onto one serial link (MSB-first, then a
// quiet gap). Optional per-source sent counters under PKT_SRC_ARB_CNT_EN.
//   state    | meaning
//   ST_IDLE  | waiting for an eligible request
//   ST_SHIFT | serialising the granted packet, valid_out high
//   ST_GAP   | forced quiet cycles so the router can drain
module pkt_src_arbiter
    import pkt_src_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PKT_W      = PKT_W_DEF,
    parameter int GAP_CYCLES = 66
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*PKT_W-1:0] pkt_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     data_out,
    output logic                     valid_out,
    output logic                     busy,
    input  logic [31:0]              paddr,
    input  logic                     psel,
    input  logic                     pen,
    input  logic                     p_write,
    input  logic [31:0]              p_wdata,
    output logic [31:0]              prdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(PKT_W);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PKT_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic               arb_en;
    logic               mode;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] last_gnt;
    logic [IW-1:0]      rr_start;
    arb_state_e         state;
    logic [PKT_W-1:0]   shreg;
    logic [BW-1:0]      bit_cnt;
    logic [GW-1:0]      gap_cnt;

    logic               wr_stb;
    logic               rd_stb;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win;
    logic [IW-1:0]      win_idx;
    logic               win_found;
    logic               can_grant;
    logic               grant_now;
    logic [PKT_W-1:0]   win_pkt;
    logic [31:0]        rdata;
    logic               unused_wdata;

    assign wr_stb       = p_write & psel & pen;
    assign rd_stb       = !p_write & psel & pen;
    assign elig         = arb_en ? (req & mask) : '0;
    // The last gap cycle doubles as the decision point, so back-to-back
    // packets are separated by exactly GAP_CYCLES quiet cycles.
    assign can_grant    = (state == ST_IDLE) || ((state == ST_GAP) && (gap_cnt == '0));
    assign grant_now    = can_grant & win_found;
    assign unused_wdata = ^p_wdata[31:NUM_REQ];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .elig    (elig),
        .start   (rr_start),
        .mode    (mode),
        .win     (win),
        .win_idx (win_idx),
        .found   (win_found)
    );

    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_pkt = pkt_data[i*PKT_W +: PKT_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_en <= 1'b0;
            mode   <= 1'b0;
            mask   <= '1;
        end else if (wr_stb) begin
            if (paddr == ADDR_CTRL) begin
                arb_en <= p_wdata[CTRL_ARB_EN];
                mode   <= p_wdata[CTRL_MODE];
            end else if (paddr == ADDR_MASK) begin
                mask <= p_wdata[NUM_REQ-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            last_gnt  <= '0;
            rr_start  <= '0;
        end else begin
            gnt <= '0;
            case (state)
                ST_SHIFT: begin
                    if (bit_cnt == '0) begin
                        state     <= ST_GAP;
                        gap_cnt   <= GAP_LAST;
                        valid_out <= 1'b0;
                        data_out  <= 1'b0;
                    end else begin
                        data_out <= shreg[PKT_W-1];
                        shreg    <= shreg << 1;
                        bit_cnt  <= bit_cnt - BW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (grant_now) begin
                state     <= ST_SHIFT;
                gnt       <= win;
                shreg     <= win_pkt << 1;
                data_out  <= win_pkt[PKT_W-1];
                valid_out <= 1'b1;
                bit_cnt   <= BIT_LAST;
                busy      <= 1'b1;
                last_gnt  <= win;
                rr_start  <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
            end
        end
    end

`ifdef PKT_SRC_ARB_CNT_EN
    logic [NUM_REQ-1:0][15:0] cnt;
    logic                     cnt_clr;

    assign cnt_clr = wr_stb && (paddr == ADDR_CNT_CLR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (grant_now && win[i]) begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (paddr == ADDR_CTRL) begin
            rdata[CTRL_ARB_EN] = arb_en;
            rdata[CTRL_MODE]   = mode;
        end else if (paddr == ADDR_MASK) begin
            rdata[NUM_REQ-1:0] = mask;
        end else if (paddr == ADDR_STATUS) begin
            rdata[1:0]         = state;
            rdata[8 +: NUM_REQ] = last_gnt;
        end
`ifdef PKT_SRC_ARB_CNT_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (paddr == ADDR_CNT_BASE + 32'(4 * i)) rdata[15:0] = cnt[i];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prdata <= '0;
        end else if (rd_stb) begin
            prdata <= rdata;
        end
    end

endmodule

// File: tb/tb_pkt_src_arbiter.sv
// Self-checking bench for pkt_src_arbiter: directed scenarios plus random
// traffic checked every cycle against a packet-level reference model.
module tb_pkt_src_arbiter;

    localparam int N = 4;
    localparam int W = 64;
    localparam int G = 66;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] pkt_data = '0;
    logic [N-1:0]   gnt;
    logic           data_out;
    logic           valid_out;
    logic           busy;
    logic [31:0]    paddr = '0;
    logic           psel = 1'b0;
    logic           pen = 1'b0;
    logic           p_write = 1'b0;
    logic [31:0]    p_wdata = '0;
    logic [31:0]    prdata;

    always #5 clk = ~clk;

    pkt_src_arbiter #(.NUM_REQ(N), .PKT_W(W), .GAP_CYCLES(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pkt_data  (pkt_data),
        .gnt       (gnt),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .paddr     (paddr),
        .psel      (psel),
        .pen       (pen),
        .p_write   (p_write),
        .p_wdata   (p_wdata),
        .prdata    (prdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: packet-level view. m_phase = -1 when idle, otherwise the
    // index of the current cycle within the packet+gap window of W+G cycles.
    int           m_phase;
    logic [W-1:0] m_pkt;
    logic         m_en, m_mode;
    logic [N-1:0] m_mask, m_last, m_gnt, m_elig;
    int           m_ptr, m_win, m_st, m_idx;
    logic [31:0]  m_prdata;
    logic [15:0]  m_cnt [N];

    function automatic logic [31:0] model_read(input logic [31:0] a, input int st);
        logic [31:0] r;
        r = 32'h0;
        if (a == 32'h0) r = {30'b0, m_mode, m_en};
        else if (a == 32'h4) r = 32'(m_mask);
        else if (a == 32'h8) r = (32'(m_last) << 8) | 32'(st);
`ifdef PKT_SRC_ARB_CNT_EN
        else if (a >= 32'h10 && a < 32'h10 + 32'(4*N) && a[1:0] == 2'b00) r = 32'(m_cnt[(a - 32'h10) >> 2]);
`endif
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = -1; m_pkt = '0; m_en = 1'b0; m_mode = 1'b0; m_mask = '1;
            m_last = '0; m_gnt = '0; m_ptr = 0; m_prdata = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 16'h0;
        end else begin
            m_st = (m_phase < 0) ? 0 : (m_phase < W) ? 1 : 2;
            if (psel && pen && !p_write) m_prdata = model_read(paddr, m_st);
            m_gnt = '0;
            if (m_phase < 0 || m_phase == W + G - 1) begin
                m_elig = m_en ? (req & m_mask) : '0;
                m_win = -1;
                for (int i = 0; i < N; i++) begin
                    m_idx = m_mode ? i : (m_ptr + i) % N;
                    if (m_win < 0 && m_elig[m_idx]) m_win = m_idx;
                end
                if (m_win >= 0) begin
                    m_phase = 0;
                    m_pkt = pkt_data[m_win*W +: W];
                    m_gnt[m_win] = 1'b1;
                    m_last = m_gnt;
                    m_ptr = (m_win + 1) % N;
                    m_cnt[m_win] = m_cnt[m_win] + 16'd1;
                end else begin
                    m_phase = -1;
                end
            end else begin
                m_phase++;
            end
            if (psel && pen && p_write) begin
                if (paddr == 32'h0) begin m_en = p_wdata[0]; m_mode = p_wdata[1]; end
                else if (paddr == 32'h4) m_mask = p_wdata[N-1:0];
`ifdef PKT_SRC_ARB_CNT_EN
                else if (paddr == 32'hC) for (int i = 0; i < N; i++) m_cnt[i] = 16'h0;
`endif
            end
        end
    end

    int   gnt_q[$];
    logic exp_valid, exp_data;

    always @(negedge clk) begin
        exp_valid = (m_phase >= 0) && (m_phase < W);
        exp_data  = 1'b0;
        if (exp_valid) exp_data = m_pkt[W-1-m_phase];
        check("mdl_gnt", gnt, m_gnt);
        check("mdl_valid", valid_out, exp_valid);
        check("mdl_data", data_out, exp_data);
        check("mdl_busy", busy, m_phase >= 0);
        check("mdl_prdata", prdata, m_prdata);
        for (int i = 0; i < N; i++) if (gnt[i]) gnt_q.push_back(i);
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); psel = 1'b1; pen = 1'b1; p_write = 1'b1; paddr = a; p_wdata = d;
        @(negedge clk); psel = 1'b0; pen = 1'b0; p_write = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); psel = 1'b1; pen = 1'b1; p_write = 1'b0; paddr = a;
        @(negedge clk); psel = 1'b0; pen = 1'b0; d = prdata;
    endtask

    task automatic reset_dut();
        @(negedge clk); rst = 1'b0; req = '0; psel = 1'b0; pen = 1'b0; p_write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_gnt(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (gnt != '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        bit ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic wait_grants(input string tag, input int n, input int limit);
        for (int c = 0; c < limit && gnt_q.size() < n; c++) @(negedge clk);
        check(tag, gnt_q.size() >= n, 1'b1);
    endtask

    task automatic check_order(input string tag, input int exp_q[$]);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < gnt_q.size()) check(tag, gnt_q[i], exp_q[i]);
            else check(tag, 64'hFFFF, exp_q[i]);
        end
    endtask

    logic [31:0] rd;
    logic [63:0] word;
    int          nv, nz, ri;
    bit          ok;
    logic [31:0] addr_tab [10] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h3};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();
        apb_read(32'h0, rd); check("rst_ctrl", rd, 32'h0);
        apb_read(32'h4, rd); check("rst_mask", rd, 32'hF);
        apb_read(32'h8, rd); check("rst_status", rd, 32'h0);

        // single packet from source 2
        apb_write(32'h0, 32'h1);
        pkt_data[2*W +: W] = 64'hA5A5_0000_FFFF_1234;
        req = 4'b0100;
        wait_gnt(300, ok);
        check("first_gnt_seen", ok, 1'b1);
        check("first_gnt", gnt, 4'b0100);
        req = '0;
        word = '0; nv = 0; nz = 0;
        for (int j = 0; j < W; j++) begin
            if (j == 1) check("gnt_one_cycle", gnt, 4'b0000);
            word = {word[62:0], data_out};
            nv += int'(valid_out);
            @(negedge clk);
        end
        check("pkt_bits", word, 64'hA5A5_0000_FFFF_1234);
        check("pkt_valid_cnt", nv, W);
        for (int j = 0; j < G; j++) begin
            nz += int'(valid_out);
            @(negedge clk);
        end
        check("gap_quiet", nz, 0);
        check("idle_after_gap", busy, 1'b0);

        // round-robin then fixed priority, all sources requesting
        reset_dut();
        for (int i = 0; i < N; i++) pkt_data[i*W +: W] = {$urandom, $urandom};
        apb_write(32'h0, 32'h1);
        gnt_q.delete();
        req = 4'hF;
        wait_grants("rr_grants", 5, 800);
        req = '0;
        check_order("rr_order", '{0, 1, 2, 3, 0});
        wait_idle("rr_idle", 300);
        apb_write(32'h0, 32'h3);
        gnt_q.delete();
        req = 4'hF;
        wait_grants("fp_grants", 3, 600);
        req = '0;
        check_order("fp_order", '{0, 0, 0});
        wait_idle("fp_idle", 300);

        // masked sources
        reset_dut();
        apb_write(32'h4, 32'hA);
        apb_write(32'h0, 32'h1);
        gnt_q.delete();
        req = 4'hF;
        wait_grants("mask_grants", 4, 700);
        req = '0;
        check_order("mask_order", '{1, 3, 1, 3});
        wait_idle("mask_idle", 300);

        // disable mid-packet: packet and gap finish, no new grant
        reset_dut();
        apb_write(32'h0, 32'h1);
        req = 4'b0001;
        wait_gnt(300, ok);
        check("dis_gnt_seen", ok, 1'b1);
        @(negedge clk);
        gnt_q.delete();
        repeat (8) @(negedge clk);
        apb_write(32'h0, 32'h0);
        wait_idle("dis_idle", 200);
        repeat (150) @(negedge clk);
        check("dis_no_regrant", gnt_q.size(), 0);
        check("dis_busy", busy, 1'b0);

        // reset mid-packet
        req = '0;
        apb_write(32'h0, 32'h1);
        pkt_data[1*W +: W] = 64'hFFFF_FFFF_FFFF_FFFF;
        req = 4'b0010;
        wait_gnt(300, ok);
        check("rst_gnt_seen", ok, 1'b1);
        repeat (29) @(negedge clk);
        check("rst_pre_valid", valid_out, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", valid_out, 1'b0);
        check("rst_data", data_out, 1'b0);
        check("rst_gnt", gnt, 4'b0000);
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apb_read(32'h8, rd); check("rst_state_idle", rd, 32'h0);

        // random traffic against the model
        apb_write(32'h4, 32'hF);
        apb_write(32'h0, 32'h1);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                ri = $urandom_range(0, N-1);
                if (!req[ri]) pkt_data[ri*W +: W] = {$urandom, $urandom};
                req[ri] = ~req[ri];
            end
            if ($urandom_range(0, 9) == 0) begin
                psel = ($urandom_range(0, 3) != 0);
                pen = ($urandom_range(0, 3) != 0);
                p_write = 1'($urandom_range(0, 1));
                paddr = addr_tab[$urandom_range(0, 9)];
                p_wdata = $urandom;
                if (paddr == 32'h0 && $urandom_range(0, 3) != 0) p_wdata[0] = 1'b1;
            end else begin
                psel = 1'b0; pen = 1'b0;
            end
        end
        psel = 1'b0; pen = 1'b0; req = '0;
        wait_idle("rand_idle", 300);

`ifdef PKT_SRC_ARB_CNT_EN
        reset_dut();
        apb_write(32'h4, 32'h2);
        apb_write(32'h0, 32'h1);
        gnt_q.delete();
        req = 4'b0010;
        wait_grants("cnt_grants", 3, 500);
        req = '0;
        wait_idle("cnt_idle", 300);
        apb_read(32'h14, rd); check("cnt_three", rd, 32'h3);
        apb_write(32'hC, 32'h0);
        apb_read(32'h14, rd); check("cnt_cleared", rd, 32'h0);
        @(negedge clk);
        force dut.cnt = {N{16'hFFFF}};
        for (int i = 0; i < N; i++) m_cnt[i] = 16'hFFFF;
        @(negedge clk);
        release dut.cnt;
        req = 4'b0010;
        wait_gnt(300, ok);
        check("cnt_wrap_gnt", ok, 1'b1);
        req = '0;
        wait_idle("cnt_wrap_idle", 300);
        apb_read(32'h14, rd); check("cnt_wrap", rd, 32'h0);
        apb_read(32'h10, rd); check("cnt_hold", rd, 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
